// File: rtl/edge_sync_filt.sv
`default_nettype none
// ============================================================================
// Module      : edge_sync_filt
// Description : Multi-channel slow-to-fast single-bit synchroniser with a
//               stability filter, per-channel edge-mode selection, a
//               one-cycle event pulse and a sticky event flag with overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sync_filt #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 2
) (
    input  logic                 clkb,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     ev_clr,
    output logic [WIDTH-1:0]     dout,
    output logic [WIDTH-1:0]     pulse,
    output logic [WIDTH-1:0]     ev_sticky,
    output logic [WIDTH-1:0]     ev_ovf
);

    // Filter counter is at least one bit wide so FILT_CYC=1 still elaborates.
    localparam int                 c_CNT_W    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_dout;
        logic                   r_pulse;
        logic                   r_sticky;
        logic                   r_ovf;
        logic                   w_s;
        logic                   w_update;
        logic                   w_event;

        // Plain flop chain on the asynchronous input; nothing between stages.
        always_ff @(posedge clkb) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], din[i]};
            end
        end

        assign w_s      = r_sync[SYNC_STAGES-1];
        // An update happens on the FILT_CYC-th consecutive disagreement.
        assign w_update = (w_s != r_dout) && (r_cnt == c_CNT_LAST);
        // Mode is looked at only here, so a mode change never disturbs dout.
        assign w_event  = w_update && (w_s ? mode[2*i] : mode[2*i+1]);

        // Stability filter: accept the synchronised level only after it has
        // disagreed with the accepted level for FILT_CYC cycles in a row.
        always_ff @(posedge clkb) begin
            if (rst) begin
                r_cnt  <= '0;
                r_dout <= 1'b0;
            end else if (w_s == r_dout) begin
                r_cnt  <= '0;
            end else if (w_update) begin
                r_dout <= w_s;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + c_CNT_ONE;
            end
        end

        // Event strobe, registered so it lines up with the new dout value.
        always_ff @(posedge clkb) begin
            if (rst) begin
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_event;
            end
        end

        // Sticky flag and overflow; a coinciding event beats a clear.
        always_ff @(posedge clkb) begin
            if (rst) begin
                r_sticky <= 1'b0;
                r_ovf    <= 1'b0;
            end else if (w_event) begin
                r_sticky <= 1'b1;
                if (ev_clr[i]) begin
                    r_ovf <= 1'b0;
                end else if (r_sticky) begin
                    r_ovf <= 1'b1;
                end
            end else if (ev_clr[i]) begin
                r_sticky <= 1'b0;
                r_ovf    <= 1'b0;
            end
        end

        assign dout[i]      = r_dout;
        assign pulse[i]     = r_pulse;
        assign ev_sticky[i] = r_sticky;
        assign ev_ovf[i]    = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_sync_filt.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_sync_filt
// Description : Self-checking bench for edge_sync_filt: directed scenarios
//               plus randomized traffic against a window-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_sync_filt;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYC    = 2;
    localparam int DEPTH       = SYNC_STAGES + FILT_CYC - 1;

    logic                 clkb;
    logic                 rst;
    logic [WIDTH-1:0]     din;
    logic [2*WIDTH-1:0]   mode;
    logic [WIDTH-1:0]     ev_clr;
    logic [WIDTH-1:0]     dout;
    logic [WIDTH-1:0]     pulse;
    logic [WIDTH-1:0]     ev_sticky;
    logic [WIDTH-1:0]     ev_ovf;

    int n_cmp;
    int n_err;
    int pc [WIDTH];

    edge_sync_filt #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYC    (FILT_CYC)
    ) u_dut (
        .clkb      (clkb),
        .rst       (rst),
        .din       (din),
        .mode      (mode),
        .ev_clr    (ev_clr),
        .dout      (dout),
        .pulse     (pulse),
        .ev_sticky (ev_sticky),
        .ev_ovf    (ev_ovf)
    );

    initial clkb = 1'b0;
    always #5 clkb = ~clkb;

    // Reference model: a channel's output flips when the last FILT_CYC
    // synchronised samples (din delayed SYNC_STAGES edges) all differ from it.
    logic [WIDTH-1:0] m_hist [DEPTH];
    logic [WIDTH-1:0] m_dout;
    logic [WIDTH-1:0] m_pulse;
    logic [WIDTH-1:0] m_st;
    logic [WIDTH-1:0] m_ovf;

    always @(posedge clkb) begin : p_model
        logic all_diff;
        logic ev;
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) m_hist[d] = '0;
            m_dout  = '0;
            m_pulse = '0;
            m_st    = '0;
            m_ovf   = '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < FILT_CYC; j++)
                    if (m_hist[SYNC_STAGES-1+j][i] == m_dout[i]) all_diff = 1'b0;
                ev = 1'b0;
                if (all_diff) begin
                    m_dout[i] = ~m_dout[i];
                    ev = m_dout[i] ? mode[2*i] : mode[2*i+1];
                end
                m_pulse[i] = ev;
                if (ev && ev_clr[i]) begin
                    m_st[i]  = 1'b1;
                    m_ovf[i] = 1'b0;
                end else if (ev) begin
                    if (m_st[i]) m_ovf[i] = 1'b1;
                    else         m_st[i]  = 1'b1;
                end else if (ev_clr[i]) begin
                    m_st[i]  = 1'b0;
                    m_ovf[i] = 1'b0;
                end
            end
            for (int d = DEPTH-1; d > 0; d--) m_hist[d] = m_hist[d-1];
            m_hist[0] = din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: outputs sampled on the falling edge and compared to the model.
    task automatic cycle();
        @(posedge clkb);
        @(negedge clkb);
        check("dout",      32'(dout),      32'(m_dout));
        check("pulse",     32'(pulse),     32'(m_pulse));
        check("ev_sticky", 32'(ev_sticky), 32'(m_st));
        check("ev_ovf",    32'(ev_ovf),    32'(m_ovf));
        for (int i = 0; i < WIDTH; i++) if (pulse[i]) pc[i]++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clr_pc();
        for (int i = 0; i < WIDTH; i++) pc[i] = 0;
    endtask

    initial begin
        logic [1:0] sweep_mode [4];
        int         sweep_exp  [4];
        sweep_mode = '{2'b01, 2'b10, 2'b11, 2'b00};
        sweep_exp  = '{1, 1, 2, 0};
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        din    = '0;
        mode   = '0;
        ev_clr = '0;
        clr_pc();

        // Reset state
        run(3);
        check("rst_dout",   32'(dout),      32'h0);
        check("rst_pulse",  32'(pulse),     32'h0);
        check("rst_sticky", 32'(ev_sticky), 32'h0);
        check("rst_ovf",    32'(ev_ovf),    32'h0);

        // din=1 at reset release is a rising edge, pulse after edge 4
        din  = 4'b0001;
        mode = 8'b0000_0001;
        rst  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("rel_pulse", 32'(pulse), (k == 4) ? 32'h1 : 32'h0);
        end
        check("rel_dout",   32'(dout[0]),      32'h1);
        check("rel_sticky", 32'(ev_sticky[0]), 32'h1);
        cycle();
        check("rel_pulse_w", 32'(pulse), 32'h0);

        // Glitch on ch1 is rejected, a long high is reported both ways
        mode = 8'hFF;
        clr_pc();
        din[1] = 1'b1;
        cycle();
        din[1] = 1'b0;
        run(6);
        check("glitch_pc",     32'(pc[1]),        32'h0);
        check("glitch_sticky", 32'(ev_sticky[1]), 32'h0);
        din[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 4) check("rise_at4", 32'(pulse[1]), 32'h1);
        end
        din[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k == 4) check("fall_at4", 32'(pulse[1]), 32'h1);
        end
        check("long_pc", 32'(pc[1]), 32'h2);

        // Mode sweep on ch2
        for (int m = 0; m < 4; m++) begin
            mode[5:4] = sweep_mode[m];
            clr_pc();
            din[2] = 1'b1;
            run(6);
            din[2] = 1'b0;
            run(6);
            check("sweep_pc", 32'(pc[2]), 32'(sweep_exp[m]));
        end

        // Sticky and overflow on ch3
        mode[7:6] = 2'b01;
        ev_clr[3] = 1'b1;
        cycle();
        ev_clr[3] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            din[3] = 1'b1;
            run(6);
            din[3] = 1'b0;
            run(6);
        end
        check("two_sticky", 32'(ev_sticky[3]), 32'h1);
        check("two_ovf",    32'(ev_ovf[3]),    32'h1);
        ev_clr[3] = 1'b1;
        cycle();
        ev_clr[3] = 1'b0;
        check("clr_sticky", 32'(ev_sticky[3]), 32'h0);
        check("clr_ovf",    32'(ev_ovf[3]),    32'h0);
        din[3] = 1'b1;
        run(6);
        din[3] = 1'b0;
        run(6);
        din[3] = 1'b1;
        run(3);
        ev_clr[3] = 1'b1;
        cycle();
        ev_clr[3] = 1'b0;
        check("coin_pulse",  32'(pulse[3]),     32'h1);
        check("coin_sticky", 32'(ev_sticky[3]), 32'h1);
        check("coin_ovf",    32'(ev_ovf[3]),    32'h0);
        din[3] = 1'b0;
        run(6);

        // All channels rising together
        mode = 8'hFF;
        din  = 4'b0000;
        run(6);
        din = 4'b1111;
        run(3);
        cycle();
        check("conc_pulse", 32'(pulse), 32'hF);
        run(4);

        // Reset in the middle of a filter count
        din = 4'b0000;
        run(6);
        din = 4'b1111;
        run(3);
        rst = 1'b1;
        cycle();
        check("midrst_dout",   32'(dout),      32'h0);
        check("midrst_pulse",  32'(pulse),     32'h0);
        check("midrst_sticky", 32'(ev_sticky), 32'h0);
        check("midrst_ovf",    32'(ev_ovf),    32'h0);
        rst = 1'b0;
        run(8);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
                ev_clr[i] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst    = 1'b0;
        ev_clr = '0;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
